// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressed RV32I data memory with load/store width decode,
// sign/zero extension and optional two-beat split of misaligned accesses.
module data_mem_lsu #(
  parameter int ADDRESS_WIDTH  = 17,
  parameter int DATA_WIDTH     = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);
  localparam int IW    = ADDRESS_WIDTH - 2;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [1:0] {IDLE, SECOND, RESP} state_t;

  logic [31:0] mem_q [DEPTH];

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lane_q, lane_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     wd_hi_q, wd_hi_d;
  logic [3:0]      be_hi_q, be_hi_d;
  logic [31:0]     hold_q, hold_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic            accept;
  logic [1:0]      lane;
  logic [IW-1:0]   idx;
  logic [3:0]      bmask;
  logic [7:0]      be8;
  logic [63:0]     wd64;
  logic            illegal, split, err;
  logic [IW-1:0]   rd_idx;
  logic [31:0]     mem_rd;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [IW-1:0]   mem_idx;
  logic [31:0]     mem_wd;

  // pair = {next word, first word}; the access starts at byte p_lane
  function automatic logic [31:0] extend(input logic [63:0] pair,
                                         input logic [1:0]  p_lane,
                                         input logic [2:0]  f3);
    logic [63:0] sh;
    sh = pair >> {p_lane, 3'b000};
    unique case (f3)
      3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  extend = {24'b0, sh[7:0]};
      3'b101:  extend = {16'b0, sh[15:0]};
      default: extend = sh[31:0];
    endcase
  endfunction

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign lane      = req_addr[1:0];
  assign idx       = req_addr[ADDRESS_WIDTH-1:2];
  assign rd_idx    = (state_q == SECOND) ? idx_q : idx;
  assign mem_rd    = mem_q[rd_idx];

  always_comb begin
    unique case (req_funct3[1:0])
      2'b00:   bmask = 4'b0001;
      2'b01:   bmask = 4'b0011;
      2'b10:   bmask = 4'b1111;
      default: bmask = 4'b0000;
    endcase
    illegal = (req_funct3[1:0] == 2'b11) ||
              (req_funct3[2] && (req_we || req_funct3[1]));
    be8     = {4'b0, bmask} << lane;
    wd64    = {32'b0, req_wdata} << {lane, 3'b000};
    split   = |be8[7:4];
    err     = illegal || (split && MISALIGN_SPLIT == 0);
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    idx_d       = idx_q;
    wd_hi_d     = wd_hi_q;
    be_hi_d     = be_hi_q;
    hold_d      = hold_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'b0;
    rsp_err_d   = 1'b0;
    mem_we      = 1'b0;
    mem_be      = 4'b0;
    mem_idx     = idx;
    mem_wd      = wd64[31:0];
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          lane_d  = lane;
          idx_d   = idx + 1'b1;
          wd_hi_d = wd64[63:32];
          be_hi_d = be8[7:4];
          hold_d  = mem_rd;
          if (err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            mem_we = req_we;
            mem_be = be8[3:0];
            if (split) begin
              state_d = SECOND;
            end else begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_rdata_d = req_we ? 32'b0
                          : extend({mem_rd, mem_rd}, lane, req_funct3);
            end
          end
        end
      end
      SECOND: begin
        mem_we      = we_q;
        mem_be      = be_hi_q;
        mem_idx     = idx_q;
        mem_wd      = wd_hi_q;
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? 32'b0
                    : extend({mem_rd, hold_q}, lane_q, f3_q);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // reset also drops a pending second beat
    if (rst) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 32'b0;
      rsp_err_d   = 1'b0;
      mem_we      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    we_q        <= we_d;
    f3_q        <= f3_d;
    lane_q      <= lane_d;
    idx_q       <= idx_d;
    wd_hi_q     <= wd_hi_d;
    be_hi_q     <= be_hi_d;
    hold_q      <= hold_d;
    rsp_valid_q <= rsp_valid_d;
    rsp_rdata_q <= rsp_rdata_d;
    rsp_err_q   <= rsp_err_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem_q[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule
